// File: rtl/bram_read_arbiter.sv
// Round-robin row-read arbiter and sequencer for the MLP weight/activation BRAM.
// Holds the read address while read_en is high, then drops read_en for one capture cycle.
module bram_read_arbiter #(
  parameter int NUM_REQ         = 2,
  parameter int DATA_WIDTH      = 8,
  parameter int MAX_OUTPUT_SIZE = 32,
  parameter int MAX_BRAM_SIZE   = 5,
  parameter int ADDR_WIDTH      = 3,
  parameter int READ_LATENCY    = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_REQ-1:0]                    req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]         req_addr,
  output logic [NUM_REQ-1:0]                    req_ready,
  output logic [NUM_REQ-1:0]                    rsp_valid,
  output logic                                  rsp_err,
  output logic [MAX_OUTPUT_SIZE*DATA_WIDTH-1:0] rsp_data,
  output logic                                  busy,
  output logic                                  bram_read_en,
  output logic [ADDR_WIDTH-1:0]                 bram_rd_addr,
  input  logic [MAX_OUTPUT_SIZE*DATA_WIDTH-1:0] bram_data_out,
  input  logic                                  bram_data_ready,
  output logic                                  err_sticky
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [PW-1:0]         rr_ptr;
  logic [PW-1:0]         grant_q;
  logic [CW-1:0]         cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  bad_q;

  logic                  gnt_found;
  logic [PW-1:0]         gnt_idx;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  addr_ok;
  logic                  cnt_last;

  function automatic logic [PW-1:0] wrap(input int a);
    return PW'(a % NUM_REQ);
  endfunction

  // First valid requester at or above rr_ptr, wrapping around.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!gnt_found && req_valid[wrap(int'(rr_ptr) + i)]) begin
        gnt_found = 1'b1;
        gnt_idx   = wrap(int'(rr_ptr) + i);
      end
    end
  end

  assign sel_addr = req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign addr_ok  = 32'(sel_addr) < 32'(MAX_BRAM_SIZE);
  assign cnt_last = cnt == CW'(READ_LATENCY - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    unique case (state_q)
      IDLE: begin
        if (gnt_found) begin
          req_ready = NUM_REQ'(1) << gnt_idx;
          state_d   = addr_ok ? ISSUE : RESP;
        end
      end
      ISSUE: begin
        if (cnt_last) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      grant_q    <= '0;
      cnt        <= '0;
      addr_q     <= '0;
      bad_q      <= 1'b0;
      rsp_data   <= '0;
      err_sticky <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (gnt_found) begin
            addr_q  <= sel_addr;
            grant_q <= gnt_idx;
            rr_ptr  <= wrap(int'(gnt_idx) + 1);
            bad_q   <= !addr_ok;
            cnt     <= '0;
            if (!addr_ok) begin
              rsp_data <= '0;
            end
          end
        end
        ISSUE: begin
          cnt <= cnt_last ? '0 : cnt + 1'b1;
        end
        CAPTURE: begin
          // Row is returned even when the BRAM flag says it is stale.
          rsp_data <= bram_data_out;
          if (!bram_data_ready) begin
            err_sticky <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy         = state_q != IDLE;
  assign bram_read_en = state_q == ISSUE;
  assign bram_rd_addr = bram_read_en ? addr_q : '0;
  assign rsp_valid    = (state_q == RESP) ? (NUM_REQ'(1) << grant_q) : '0;
  assign rsp_err      = (state_q == RESP) && bad_q;

endmodule

// File: tb/tb_bram_read_arbiter.sv
// Bench for bram_read_arbiter: BRAM model, timing-arithmetic reference model,
// directed steps followed by a randomized request phase.
module tb_bram_read_arbiter;

  localparam int N   = 2;
  localparam int DW  = 8;
  localparam int MOS = 32;
  localparam int MBS = 5;
  localparam int AW  = 3;
  localparam int RL  = 2;
  localparam int W   = MOS * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]  req_ready;
  logic [N-1:0]  rsp_valid;
  logic          rsp_err;
  logic [W-1:0]  rsp_data;
  logic          busy;
  logic          bram_read_en;
  logic [AW-1:0] bram_rd_addr;
  logic [W-1:0]  bram_data_out = '0;
  logic          bram_data_ready = 1'b0;
  logic          err_sticky;

  bram_read_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .MAX_OUTPUT_SIZE(MOS),
    .MAX_BRAM_SIZE(MBS), .ADDR_WIDTH(AW), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_err(rsp_err), .rsp_data(rsp_data), .busy(busy),
    .bram_read_en(bram_read_en), .bram_rd_addr(bram_rd_addr),
    .bram_data_out(bram_data_out), .bram_data_ready(bram_data_ready),
    .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  logic [W-1:0] mem [8];
  bit hold_not_ready = 1'b0;
  int bcnt = 0;

  // BRAM: row valid after RL consecutive enabled cycles; dropping enable resets it.
  always @(posedge clk) begin
    if (bram_read_en) begin
      if (bcnt + 1 >= RL) begin
        bram_data_out   <= mem[bram_rd_addr];
        bram_data_ready <= !hold_not_ready;
      end
      bcnt <= bcnt + 1;
    end else begin
      bcnt            <= 0;
      bram_data_ready <= 1'b0;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  bit          pend [N];
  logic [AW-1:0] paddr [N];
  bit          rearm [N];
  bit          rand_mode = 1'b0;

  int cyc, free_at, rr, t_acc, rsp_at, tg;
  bit tbad, tnr, sticky;
  logic [AW-1:0] taddr;
  logic [W-1:0]  last_data;

  task automatic model_reset();
    free_at   = cyc;
    rr        = 0;
    rsp_at    = -1;
    t_acc     = -100;
    tbad      = 1'b1;
    sticky    = 1'b0;
    last_data = '0;
  endtask

  task automatic model_eval();
    logic [N-1:0]  e_ready = '0;
    logic [N-1:0]  e_rv = '0;
    logic          e_err = 1'b0;
    logic          e_ren = 1'b0;
    logic [AW-1:0] e_addr = '0;
    logic          e_busy = cyc < free_at;
    bit            found = 1'b0;
    int            g = 0;
    if (cyc < free_at) begin
      if (!tbad && cyc >= t_acc + 1 && cyc <= t_acc + RL) begin
        e_ren  = 1'b1;
        e_addr = taddr;
      end
      if (cyc == rsp_at) begin
        e_rv      = N'(1) << tg;
        e_err     = tbad;
        last_data = tbad ? '0 : mem[taddr];
        if (!tbad && tnr) sticky = 1'b1;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!found && pend[(rr + k) % N]) begin
          found = 1'b1;
          g     = (rr + k) % N;
        end
      end
      if (found) begin
        e_ready = N'(1) << g;
        t_acc   = cyc;
        tg      = g;
        taddr   = paddr[g];
        tbad    = int'(paddr[g]) >= MBS;
        tnr     = hold_not_ready;
        rsp_at  = tbad ? cyc + 1 : cyc + RL + 2;
        free_at = rsp_at + 1;
        rr      = (g + 1) % N;
        if (!rearm[g]) pend[g] = 1'b0;
      end
    end
    chk("req_ready", W'(req_ready), W'(e_ready));
    chk("rsp_valid", W'(rsp_valid), W'(e_rv));
    chk("rsp_err", W'(rsp_err), W'(e_err));
    chk("busy", W'(busy), W'(e_busy));
    chk("bram_read_en", W'(bram_read_en), W'(e_ren));
    chk("bram_rd_addr", W'(bram_rd_addr), W'(e_addr));
    chk("rsp_data", rsp_data, last_data);
    chk("err_sticky", W'(err_sticky), W'(sticky));
    cyc++;
  endtask

  task automatic step(input bit r);
    @(negedge clk);
    rst = r;
    if (r) begin
      for (int i = 0; i < N; i++) begin
        pend[i]  = 1'b0;
        rearm[i] = 1'b0;
      end
    end else if (rand_mode) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            pend[i]  = 1'b1;
            paddr[i] = AW'($urandom_range(0, 7));
          end
        end else if ($urandom_range(0, 15) == 0) begin
          pend[i] = 1'b0;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      req_valid[i]           = pend[i];
      req_addr[i*AW +: AW]   = paddr[i];
    end
    #1;
    model_eval();
    if (r) model_reset();
  endtask

  task automatic run(input int n);
    repeat (n) step(1'b0);
  endtask

  task automatic ask(input int i, input int a);
    pend[i]  = 1'b1;
    paddr[i] = AW'(a);
  endtask

  initial begin
    for (int r = 0; r < 8; r++) begin
      for (int e = 0; e < MOS; e++) begin
        mem[r][e*DW +: DW] = DW'($urandom);
      end
    end
    mem[1] = '0;
    mem[1][0*DW +: DW] = 8'h00;
    mem[1][1*DW +: DW] = 8'h02;
    mem[1][2*DW +: DW] = 8'h04;
    mem[1][3*DW +: DW] = 8'h01;
    mem[2][0*DW +: DW] = 8'h03;
    for (int i = 0; i < N; i++) begin
      pend[i]  = 1'b0;
      rearm[i] = 1'b0;
      paddr[i] = '0;
    end
    rst       = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    repeat (3) @(posedge clk);
    cyc = 0;
    model_reset();
    run(2);

    // single good read by requester 0
    ask(0, 1);
    run(8);

    // both requesters held continuously: alternating grants
    rearm[0] = 1'b1;
    rearm[1] = 1'b1;
    ask(0, 0);
    ask(1, 2);
    run(22);
    rearm[0] = 1'b0;
    rearm[1] = 1'b0;
    run(12);

    // out-of-range address
    ask(1, 6);
    run(4);

    // reset during the second ISSUE cycle
    ask(0, 0);
    run(2);
    step(1'b1);
    ask(0, 2);
    ask(1, 2);
    run(14);

    // stale BRAM flag at capture, sticky until reset
    hold_not_ready = 1'b1;
    ask(1, 3);
    run(7);
    hold_not_ready = 1'b0;
    ask(0, 4);
    run(7);
    step(1'b1);
    run(2);

    // back-to-back reads by one requester
    ask(0, 0);
    run(1);
    ask(0, 2);
    run(10);

    // randomized traffic
    rand_mode = 1'b1;
    run(400);
    rand_mode = 1'b0;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    run(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
